// File: rtl/exc_pkg.sv
// Shared definitions for the exception/interrupt controller: FSM states,
// CSR map, CAUSE codes, STATUS bit positions and the trap vectors used by the PC.
package exc_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_TRAP,
    ST_HANDLER
  } exc_state_t;

  localparam logic [1:0] CSR_STATUS = 2'd0;
  localparam logic [1:0] CSR_CAUSE  = 2'd1;
  localparam logic [1:0] CSR_EPC    = 2'd2;

  localparam logic [4:0] CAUSE_INT = 5'd0;
  localparam logic [4:0] CAUSE_ILL = 5'd10;
  localparam logic [4:0] CAUSE_OVF = 5'd12;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int STATUS_IM  = 8;
  localparam int CAUSE_CODE = 2;
  localparam int CAUSE_IP   = 8;

  localparam logic [31:0] VEC_RESET = 32'h8000_0000;
  localparam logic [31:0] VEC_EXC   = 32'h8000_0004;
  localparam logic [31:0] VEC_IRQ   = 32'h8000_0008;

endpackage

// File: rtl/exc_ctrl_if.sv
// CSR access bus of the exception controller; the core is master, exc_ctrl is slave.
interface exc_ctrl_if;
  logic        csr_we;
  logic [1:0]  csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;

  modport master (output csr_we, csr_addr, csr_wdata, input csr_rdata);
  modport slave  (input csr_we, csr_addr, csr_wdata, output csr_rdata);
endinterface

// File: rtl/exc_ctrl_irq_sync.sv
// Per-bit two-flop synchronizer for asynchronous interrupt request lines.
module irq_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/exc_ctrl.sv
// Trap controller: raises irq/Exception redirect pulses, keeps STATUS/CAUSE/EPC
// and handles eret. Define IRQ_SYNC_EN to pass ext_irq through a 2-flop synchronizer.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int         NIRQ    = 8,
  parameter logic [4:0] EXC_OVF = CAUSE_OVF,
  parameter logic [4:0] EXC_ILL = CAUSE_ILL
) (
  input  logic            clk,
  input  logic            reset,
  exc_ctrl_if.slave       csr,
  input  logic [NIRQ-1:0] ext_irq,
  input  logic            exc_ovf,
  input  logic            exc_ill,
  input  logic [31:0]     ia,
  input  logic [31:0]     pcin,
  input  logic            eret,
  output logic            irq,
  output logic            Exception,
  output logic            epc_sel,
  output logic [31:0]     epc
);
  exc_state_t      state;
  logic            ie_q;
  logic            exl_q;
  logic [NIRQ-1:0] im_q;
  logic [NIRQ-1:0] ip_q;
  logic [4:0]      code_q;
  logic [NIRQ-1:0] irq_in;
  logic            take_int;
  logic            exc_any;
  logic [4:0]      exc_code;

`ifdef IRQ_SYNC_EN
  irq_sync #(.W(NIRQ)) u_irq_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ext_irq),
    .q     (irq_in)
  );
`else
  assign irq_in = ext_irq;
`endif

  // IP is a live view of the request lines; nothing is latched beyond this stage.
  // NOTE: reset is sampled on the clock edge, so every register clears inside its always_ff.
  always_ff @(posedge clk) begin
    if (!reset) ip_q <= '0;
    else        ip_q <= irq_in;
  end

  assign take_int = ie_q & ~exl_q & (|(ip_q & im_q));
  assign exc_any  = exc_ovf | exc_ill;
  assign exc_code = exc_ovf ? EXC_OVF : EXC_ILL;

  // NOTE: state uses non-blocking assignments so later trap updates override the CSR write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_RUN;
      ie_q      <= 1'b0;
      exl_q     <= 1'b0;
      im_q      <= '1;
      code_q    <= CAUSE_INT;
      epc       <= '0;
      irq       <= 1'b0;
      Exception <= 1'b0;
      epc_sel   <= 1'b0;
    end else begin
      irq       <= 1'b0;
      Exception <= 1'b0;
      epc_sel   <= 1'b0;

      if (csr.csr_we) begin
        if (csr.csr_addr == CSR_STATUS) begin
          ie_q  <= csr.csr_wdata[STATUS_IE];
          exl_q <= csr.csr_wdata[STATUS_EXL];
          im_q  <= csr.csr_wdata[STATUS_IM +: NIRQ];
        end else if (csr.csr_addr == CSR_EPC) begin
          epc <= csr.csr_wdata;
        end
      end

      unique case (state)
        ST_RUN: begin
          if (exc_any) begin
            Exception <= 1'b1;
            epc       <= ia;
            code_q    <= exc_code;
            exl_q     <= 1'b1;
            state     <= ST_TRAP;
          end else if (take_int) begin
            irq    <= 1'b1;
            epc    <= pcin;
            code_q <= CAUSE_INT;
            exl_q  <= 1'b1;
            state  <= ST_TRAP;
          end
        end
        // Fetch is being flushed here; faults from squashed instructions are dropped.
        ST_TRAP: state <= ST_HANDLER;
        ST_HANDLER: begin
          if (exc_any) begin
            Exception <= 1'b1;
            code_q    <= exc_code;
            exl_q     <= 1'b1;
            state     <= ST_TRAP;
          end else if (eret) begin
            epc_sel <= 1'b1;
            exl_q   <= 1'b0;
            state   <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // NOTE: rdata gets a zero default first so no path through the case infers a latch.
  always_comb begin
    csr.csr_rdata = '0;
    unique case (csr.csr_addr)
      CSR_STATUS: begin
        csr.csr_rdata[STATUS_IE]         = ie_q;
        csr.csr_rdata[STATUS_EXL]        = exl_q;
        csr.csr_rdata[STATUS_IM +: NIRQ] = im_q;
      end
      CSR_CAUSE: begin
        csr.csr_rdata[CAUSE_CODE +: 5]  = code_q;
        csr.csr_rdata[CAUSE_IP +: NIRQ] = ip_q;
      end
      CSR_EPC: csr.csr_rdata = epc;
      default: csr.csr_rdata = '0;
    endcase
  end
endmodule
